boot_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It consumes a byte stream from a serial receiver, frames it into a length-prefixed, checksummed image, and writes 32-bit words into the instruction memory's write port. It holds the core in reset until a complete, valid image has been written, then releases it permanently.

---
 rtl/boot_pkg.sv | 18 +
 rtl/boot_word_packer.sv | 41 ++++
 rtl/boot_loader.sv | 153 +++++++++++++++
 tb/tb_boot_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM states, default sync marker
// and frame length field width.
package boot_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned LEN_W         = 16;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHK,
    S_ERR,
    S_DONE
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Collects accepted payload bytes into a little-endian 32-bit word and flags
// the byte that completes it.
module boot_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shreg_q, shreg_d;

  // Only the three earlier bytes are stored; the completing byte goes straight out.
  assign word_o      = {byte_i, shreg_q};
  assign word_done_o = byte_valid_i && !clr_i && (byte_cnt_q == 2'd3);

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    if (clr_i) begin
      byte_cnt_d = '0;
    end else if (byte_valid_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shreg_d    = {byte_i, shreg_q[23:8]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Frames a length-prefixed, XOR-checksummed byte stream into instruction memory
// writes and holds the core in reset until a valid image has been loaded.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              boot_done,
  output logic              boot_err
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

  boot_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d, cnt_inc;
  logic [7:0]        chk_q, chk_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pk_clr, pk_valid, pk_done;
  logic [31:0]       pk_word;
  logic [LEN_W-1:0]  len_full;

  boot_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  assign accept   = rx_valid && rx_ready_q;
  assign cnt_inc  = word_cnt_q + CW'(1);
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    pk_clr     = 1'b0;
    pk_valid   = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d    = S_LEN0;
          err_d      = 1'b0;
          chk_d      = '0;
          word_cnt_d = '0;
          pk_clr     = 1'b1;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          chk_d      = chk_q ^ rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d  = len_full;
          chk_d  = chk_q ^ rx_data;
          if (len_full > DEPTH_L)     state_d = S_ERR;
          else if (len_full == '0)    state_d = S_CHK;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d    = chk_q ^ rx_data;
          pk_valid = 1'b1;
          if (pk_done) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = pk_word;
            word_cnt_d = cnt_inc;
            if (LEN_W'(cnt_inc) == len_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
      S_ERR:   state_d = S_SYNC;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_SYNC;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
    // Ready is registered from the next state so it never depends on rx_valid.
    rx_ready_d = !(state_d == S_ERR || state_d == S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_SYNC;
      len_q      <= '0;
      word_cnt_q <= '0;
      chk_q      <= '0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      chk_q      <= chk_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign boot_done  = done_q;
  assign core_rst_n = done_q;
  assign boot_err   = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized scoreboard bench for boot_loader: frames are built from word lists,
// expected writes queued from the frame contents and checked by a write monitor.
module tb_boot_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          boot_done;
  logic          boot_err;

  boot_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  wr_t         exp_q[$];
  logic [31:0] words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got rx_ready %b expected 1", rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  function automatic int unsigned pick_gap(input int unsigned maxgap);
    return (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
  endfunction

  // Frame-level reference: the image is the word list; CHK is the XOR of the
  // length and payload bytes; oversized frames write nothing and fail.
  task automatic send_frame(input logic [15:0] len, input bit bad, input int unsigned maxgap);
    logic [7:0]  x;
    logic [31:0] w;
    wr_t         e;
    x = len[7:0] ^ len[15:8];
    send_byte(8'hA5, pick_gap(maxgap));
    chk("err_cleared_by_sync", 32'(boot_err), 32'd0);
    send_byte(len[7:0], pick_gap(maxgap));
    send_byte(len[15:8], pick_gap(maxgap));
    if (32'(len) > DEPTH) begin
      chk("oversize_err", 32'(boot_err), 32'd1);
      chk("oversize_ready", 32'(rx_ready), 32'd0);
      chk("oversize_no_release", 32'(core_rst_n), 32'd0);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      w      = words[i];
      e.addr = AW'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        x = x ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], pick_gap(maxgap));
        if (k == 3) chk("write_latency", 32'(imem_we), 32'd1);
      end
    end
    send_byte(bad ? (x ^ 8'h01) : x, pick_gap(maxgap));
    chk("boot_done", 32'(boot_done), bad ? 32'd0 : 32'd1);
    chk("core_rst_n", 32'(core_rst_n), bad ? 32'd0 : 32'd1);
    chk("boot_err", 32'(boot_err), bad ? 32'd1 : 32'd0);
    chk("ready_after_chk", 32'(rx_ready), 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rx_ready), 32'd1);
    chk("post_rst_core", 32'(core_rst_n), 32'd0);
  endtask

  task automatic load_plan_words();
    words.delete();
    words.push_back(32'h00A00513);
    words.push_back(32'h00500093);
  endtask

  initial begin
    logic [7:0] g;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();

    for (int i = 0; i < 3; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, 0);
    end
    chk("garbage_no_err", 32'(boot_err), 32'd0);

    send_frame(16'h0401, 1'b0, 0);

    load_plan_words();
    send_frame(16'd2, 1'b1, 0);

    for (int r = 0; r < 4; r++) begin
      int unsigned n;
      n = $urandom_range(1, 8);
      words.delete();
      for (int i = 0; i < int'(n); i++) words.push_back($urandom());
      send_frame(16'(n), 1'b1, 5);
    end

    // Reset after six payload bytes: only the first complete word is written.
    words.delete();
    words.push_back($urandom());
    words.push_back($urandom());
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    begin
      wr_t e;
      e.addr = '0;
      e.data = words[0];
      exp_q.push_back(e);
    end
    for (int b = 0; b < 6; b++) begin
      logic [31:0] w;
      w = words[b / 4];
      send_byte(w[8*(b%4) +: 8], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_write", 32'(imem_we), 32'd0);
    chk("midrst_drained", exp_q.size(), 32'd0);
    rst = 1'b1;

    load_plan_words();
    send_frame(16'd2, 1'b0, 5);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("done_sticky", 32'(boot_done), 32'd1);
    chk("done_ready_low", 32'(rx_ready), 32'd0);

    do_reset();
    words.delete();
    for (int i = 0; i < int'(DEPTH); i++) words.push_back($urandom());
    send_frame(16'(DEPTH), 1'b0, 0);

    do_reset();
    send_frame(16'd0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
